// File: rtl/bsg_cache_nb_pkg.sv
// Shared types and helpers for the non-blocking cache tag-buffer drain logic.
package bsg_cache_nb_pkg;

  typedef enum logic [1:0] {
    e_drain_idle = 2'd0,
    e_drain_rd   = 2'd1,
    e_drain_cap  = 2'd2,
    e_drain_wr   = 2'd3
  } bsg_cache_nb_tbuf_drain_state_e;

  // Number of byte-offset bits below the set index.
  function automatic int bsg_cache_nb_block_offset_width(input int words, input int word_w);
    return $clog2(words * word_w / 8);
  endfunction

endpackage

// File: rtl/bsg_cache_nb_tbuf_drain_if.sv
// Bundle of tbuf head, pipeline arbitration and stat-mem request signals seen by the drain engine.
interface bsg_cache_nb_tbuf_drain_if #(
  parameter int addr_width_p = 32,
  parameter int ways_p       = 4,
  parameter int sets_p       = 64
);
  localparam int lg_ways_lp = $clog2(ways_p);
  localparam int lg_sets_lp = $clog2(sets_p);
  localparam int stat_w_lp  = 2 * ways_p - 1;

  logic [addr_width_p-1:0] tbuf_addr_i;
  logic [lg_ways_lp-1:0]   tbuf_way_i;
  logic                    tbuf_v_i;
  logic                    tbuf_full_i;
  logic                    tbuf_yumi_o;
  logic                    pipe_stat_req_i;
  logic                    drain_i;
  logic                    stat_mem_v_o;
  logic                    stat_mem_w_o;
  logic [lg_sets_lp-1:0]   stat_mem_addr_o;
  logic [stat_w_lp-1:0]    stat_mem_data_o;
  logic                    stat_mem_gnt_i;
  logic [stat_w_lp-1:0]    stat_mem_data_i;
  logic                    lock_o;
  logic                    idle_o;

  modport master (
    input  tbuf_addr_i, tbuf_way_i, tbuf_v_i, tbuf_full_i,
    output tbuf_yumi_o,
    input  pipe_stat_req_i, drain_i,
    output stat_mem_v_o, stat_mem_w_o, stat_mem_addr_o, stat_mem_data_o,
    input  stat_mem_gnt_i, stat_mem_data_i,
    output lock_o, idle_o
  );

  modport slave (
    output tbuf_addr_i, tbuf_way_i, tbuf_v_i, tbuf_full_i,
    input  tbuf_yumi_o,
    output pipe_stat_req_i, drain_i,
    input  stat_mem_v_o, stat_mem_w_o, stat_mem_addr_o, stat_mem_data_o,
    output stat_mem_gnt_i, stat_mem_data_i,
    input  lock_o, idle_o
  );

endinterface

// File: rtl/bsg_cache_nb_plru_update.sv
// Tree pseudo-LRU update: every node on the root-to-leaf path of way_i is turned to point away from it.
module bsg_cache_nb_plru_update #(
  parameter int ways_p = 4
) (
  input  logic [ways_p-2:0]         lru_i,
  input  logic [$clog2(ways_p)-1:0] way_i,
  output logic [ways_p-2:0]         lru_o
);
  localparam int lg_ways_lp = $clog2(ways_p);

  // Heap numbering: level l holds nodes (2^l - 1) .. (2^(l+1) - 2); node k of level l is on
  // the path iff the top l bits of the way equal k. A 1 means the next victim is on the right.
  for (genvar l = 0; l < lg_ways_lp; l++) begin : g_lvl
    for (genvar k = 0; k < (1 << l); k++) begin : g_node
      logic on_path;
      assign on_path = (int'(way_i >> (lg_ways_lp - l)) == k);
      assign lru_o[(1 << l) - 1 + k] = on_path ? ~way_i[lg_ways_lp-1-l]
                                               : lru_i[(1 << l) - 1 + k];
    end
  end

endmodule

// File: rtl/bsg_cache_nb_tbuf_drain.sv
// Pops tag-buffer store records and read-modify-writes the stat memory (dirty bit + PLRU) per entry.
module bsg_cache_nb_tbuf_drain
  import bsg_cache_nb_pkg::*;
#(
  parameter int addr_width_p          = 32,
  parameter int ways_p                = 4,
  parameter int sets_p                = 64,
  parameter int block_size_in_words_p = 8,
  parameter int word_width_p          = 32
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  bsg_cache_nb_tbuf_drain_if.master bus
);
  localparam int lg_ways_lp       = $clog2(ways_p);
  localparam int lg_sets_lp       = $clog2(sets_p);
  localparam int block_offset_lp  = bsg_cache_nb_block_offset_width(block_size_in_words_p, word_width_p);

  typedef struct packed {
    logic [ways_p-1:0] dirty;
    logic [ways_p-2:0] lru;
  } stat_info_s;

  bsg_cache_nb_tbuf_drain_state_e state_r, state_n;
  logic [lg_sets_lp-1:0] idx_r;
  logic [lg_ways_lp-1:0] way_r;
  stat_info_s            new_r;
  stat_info_s            rd_info;
  stat_info_s            upd_info;
  logic [ways_p-2:0]     lru_new;
  logic [ways_p-1:0]     way_onehot;
  logic                  start;
  logic                  unused_addr;

  // Only the set-index bits matter; the rest of the address is carried for the tbuf's benefit.
  assign unused_addr = ^bus.tbuf_addr_i;

  // A pending pipeline access wins unless the tbuf is full or a drain is forced.
  assign start   = bus.tbuf_v_i & (bus.drain_i | bus.tbuf_full_i | ~bus.pipe_stat_req_i);
  assign rd_info = bus.stat_mem_data_i;

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_drain_idle: if (start)              state_n = e_drain_rd;
      e_drain_rd:   if (bus.stat_mem_gnt_i) state_n = e_drain_cap;
      e_drain_cap:                          state_n = e_drain_wr;
      e_drain_wr:   if (bus.stat_mem_gnt_i) state_n = e_drain_idle;
      default:                              state_n = e_drain_idle;
    endcase
  end

  assign way_onehot = {{(ways_p-1){1'b0}}, 1'b1} << way_r;

  bsg_cache_nb_plru_update #(.ways_p(ways_p)) plru (
    .lru_i (rd_info.lru),
    .way_i (way_r),
    .lru_o (lru_new)
  );

  assign upd_info = {rd_info.dirty | way_onehot, lru_new};

  // The head entry is latched at launch so a tbuf_v_i drop mid-operation cannot disturb it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_drain_idle;
      idx_r   <= '0;
      way_r   <= '0;
      new_r   <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == e_drain_idle && start) begin
        idx_r <= bus.tbuf_addr_i[block_offset_lp +: lg_sets_lp];
        way_r <= bus.tbuf_way_i;
      end
      if (state_r == e_drain_cap)
        new_r <= upd_info;
    end
  end

  assign bus.stat_mem_v_o    = (state_r == e_drain_rd) | (state_r == e_drain_wr);
  assign bus.stat_mem_w_o    = (state_r == e_drain_wr);
  assign bus.stat_mem_addr_o = idx_r;
  assign bus.stat_mem_data_o = new_r;
  // Pop only once the write is committed, so a reset mid-operation leaves the entry to be redone.
  assign bus.tbuf_yumi_o     = (state_r == e_drain_wr) & bus.stat_mem_gnt_i;
  assign bus.lock_o          = (state_r == e_drain_cap) | (state_r == e_drain_wr);
  assign bus.idle_o          = (state_r == e_drain_idle);

endmodule

// File: tb/tb_bsg_cache_nb_tbuf_drain.sv
// Directed bench for the tbuf drain engine: 4-way instance for directed scenarios, 2-way for a random sweep.
module tb_bsg_cache_nb_tbuf_drain;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   yumi4 = 0;

  always #5 clk = ~clk;

  bsg_cache_nb_tbuf_drain_if #(.addr_width_p(16), .ways_p(4), .sets_p(64)) b4 ();
  bsg_cache_nb_tbuf_drain_if #(.addr_width_p(16), .ways_p(2), .sets_p(8))  b2 ();

  bsg_cache_nb_tbuf_drain #(
    .addr_width_p(16), .ways_p(4), .sets_p(64),
    .block_size_in_words_p(16), .word_width_p(32)
  ) dut4 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (b4)
  );

  bsg_cache_nb_tbuf_drain #(
    .addr_width_p(16), .ways_p(2), .sets_p(8),
    .block_size_in_words_p(4), .word_width_p(32)
  ) dut2 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (b2)
  );

  // Stat memory models: 1RW sync SRAM, read data valid the cycle after a granted read.
  logic [6:0] mem4 [64] = '{default: '0};
  logic [6:0] rd4 = '0;
  logic [2:0] mem2 [8] = '{default: '0};
  logic [2:0] rd2 = '0;
  logic [2:0] ref2 [8] = '{default: '0};

  always @(posedge clk) begin
    if (b4.stat_mem_v_o && b4.stat_mem_gnt_i) begin
      if (b4.stat_mem_w_o) mem4[b4.stat_mem_addr_o] <= b4.stat_mem_data_o;
      else                 rd4 <= mem4[b4.stat_mem_addr_o];
    end
    if (b2.stat_mem_v_o && b2.stat_mem_gnt_i) begin
      if (b2.stat_mem_w_o) mem2[b2.stat_mem_addr_o] <= b2.stat_mem_data_o;
      else                 rd2 <= mem2[b2.stat_mem_addr_o];
    end
    if (b4.tbuf_yumi_o) yumi4 <= yumi4 + 1;
  end

  assign b4.stat_mem_data_i = rd4;
  assign b2.stat_mem_data_i = rd2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        done;
    logic [15:0] a;
    logic        wy;
    int          idx;

    reset_n = 1'b0;
    b4.tbuf_addr_i = '0; b4.tbuf_way_i = '0; b4.tbuf_v_i = 1'b0; b4.tbuf_full_i = 1'b0;
    b4.pipe_stat_req_i = 1'b0; b4.drain_i = 1'b0; b4.stat_mem_gnt_i = 1'b0;
    b2.tbuf_addr_i = '0; b2.tbuf_way_i = '0; b2.tbuf_v_i = 1'b0; b2.tbuf_full_i = 1'b0;
    b2.pipe_stat_req_i = 1'b0; b2.drain_i = 1'b0; b2.stat_mem_gnt_i = 1'b0;

    // Reset values
    #3;
    check("rst_yumi", b4.tbuf_yumi_o, 0);
    check("rst_v",    b4.stat_mem_v_o, 0);
    check("rst_w",    b4.stat_mem_w_o, 0);
    check("rst_lock", b4.lock_o, 0);
    check("rst_idle", b4.idle_o, 1);
    check("rst_addr", b4.stat_mem_addr_o, 0);
    check("rst_data", b4.stat_mem_data_o, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single entry 0x1040 way 2 -> set 1, dirty 0100, lru 100
    b4.tbuf_addr_i = 16'h1040; b4.tbuf_way_i = 2'd2; b4.tbuf_v_i = 1'b1; b4.stat_mem_gnt_i = 1'b1;
    check("t1_idle", b4.idle_o, 1);
    tick();
    check("t1_rd_v",    b4.stat_mem_v_o, 1);
    check("t1_rd_w",    b4.stat_mem_w_o, 0);
    check("t1_rd_addr", b4.stat_mem_addr_o, 1);
    check("t1_rd_lock", b4.lock_o, 0);
    tick();
    check("t1_cap_v",    b4.stat_mem_v_o, 0);
    check("t1_cap_lock", b4.lock_o, 1);
    tick();
    check("t1_wr_v",    b4.stat_mem_v_o, 1);
    check("t1_wr_w",    b4.stat_mem_w_o, 1);
    check("t1_wr_data", b4.stat_mem_data_o, 7'b0100_100);
    check("t1_wr_yumi", b4.tbuf_yumi_o, 1);
    tick();
    b4.tbuf_v_i = 1'b0;
    check("t1_back_idle", b4.idle_o, 1);
    check("t1_mem",       mem4[1], 7'b0100_100);
    check("t1_yumi_cnt",  yumi4, 1);

    // Pipeline priority, then tbuf_full forces the drain; grants withheld in RD and WR
    b4.tbuf_addr_i = 16'h0140; b4.tbuf_way_i = 2'd1; b4.tbuf_v_i = 1'b1;
    b4.pipe_stat_req_i = 1'b1; b4.stat_mem_gnt_i = 1'b0;
    tick();
    check("t2_hold_idle0", b4.idle_o, 1);
    check("t2_hold_v0",    b4.stat_mem_v_o, 0);
    tick();
    check("t2_hold_idle1", b4.idle_o, 1);
    b4.tbuf_full_i = 1'b1;
    tick();
    b4.tbuf_full_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_rd_v",    b4.stat_mem_v_o, 1);
      check("t2_rd_addr", b4.stat_mem_addr_o, 5);
      check("t2_rd_lock", b4.lock_o, 0);
      tick();
    end
    b4.stat_mem_gnt_i = 1'b1;
    tick();
    check("t2_cap_lock", b4.lock_o, 1);
    b4.stat_mem_gnt_i = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      check("t2_wr_v",    b4.stat_mem_v_o, 1);
      check("t2_wr_w",    b4.stat_mem_w_o, 1);
      check("t2_wr_lock", b4.lock_o, 1);
      check("t2_wr_yumi", b4.tbuf_yumi_o, 0);
      tick();
    end
    b4.stat_mem_gnt_i = 1'b1;
    #1;
    check("t2_wr_yumi_gnt", b4.tbuf_yumi_o, 1);
    check("t2_wr_data",     b4.stat_mem_data_o, 7'b0010_001);
    tick();
    b4.tbuf_v_i = 1'b0; b4.pipe_stat_req_i = 1'b0;
    check("t2_idle",     b4.idle_o, 1);
    check("t2_yumi_cnt", yumi4, 2);
    check("t2_mem",      mem4[5], 7'b0010_001);

    // Back-to-back same set: way 0 then way 3
    b4.tbuf_addr_i = 16'h2080; b4.tbuf_way_i = 2'd0; b4.tbuf_v_i = 1'b1; b4.stat_mem_gnt_i = 1'b1;
    tick(); tick(); tick();
    check("t3_wr0_data", b4.stat_mem_data_o, 7'b0001_011);
    check("t3_wr0_yumi", b4.tbuf_yumi_o, 1);
    tick();
    b4.tbuf_way_i = 2'd3;
    check("t3_idle", b4.idle_o, 1);
    tick(); tick();
    check("t3_rd1_data", b4.stat_mem_data_i, 7'b0001_011);
    tick();
    check("t3_wr1_data", b4.stat_mem_data_o, 7'b1001_010);
    tick();
    b4.tbuf_v_i = 1'b0;
    check("t3_mem",       mem4[2], 7'b1001_010);
    check("t3_dirty",     mem4[2][6:3], 4'b1001);
    check("t3_yumi_cnt",  yumi4, 4);

    // Asynchronous reset while in CAP; entry stays and is drained once afterwards
    b4.tbuf_addr_i = 16'h00C0; b4.tbuf_way_i = 2'd1; b4.tbuf_v_i = 1'b1;
    tick(); tick();
    check("t4_cap_lock", b4.lock_o, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_rst_lock", b4.lock_o, 0);
    check("t4_rst_idle", b4.idle_o, 1);
    check("t4_rst_v",    b4.stat_mem_v_o, 0);
    check("t4_rst_yumi", b4.tbuf_yumi_o, 0);
    tick(); tick();
    reset_n = 1'b1;
    check("t4_no_yumi", yumi4, 4);
    done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      tick();
      if (b4.tbuf_yumi_o) done = 1'b1;
    end
    check("t4_redrain_done", done, 1);
    tick();
    b4.tbuf_v_i = 1'b0;
    check("t4_mem", mem4[3], 7'b0010_001);
    tick(); tick();
    check("t4_yumi_once", yumi4, 5);

    // ways_p=2 sweep with random grants against a reference dirty/PLRU table
    for (int n = 0; n < 24; n++) begin
      a   = 16'($urandom);
      wy  = 1'($urandom_range(0, 1));
      idx = int'(a[6:4]);
      b2.tbuf_addr_i = a; b2.tbuf_way_i = wy; b2.tbuf_v_i = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        b2.stat_mem_gnt_i = 1'($urandom_range(0, 1));
        #1;
        if (b2.tbuf_yumi_o) done = 1'b1;
        tick();
      end
      b2.tbuf_v_i = 1'b0; b2.stat_mem_gnt_i = 1'b0;
      check("sweep_done", done, 1);
      ref2[idx] = {ref2[idx][2:1] | (wy ? 2'b10 : 2'b01), ~wy};
      check("sweep_stat", mem2[idx], ref2[idx]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
